// File: rtl/qam64_pkg.sv
// Shared 64-QAM constants: symbol/axis widths, demapper state encoding and
// the odd constellation levels common to the mapper and demapper.
package qam64_pkg;

    localparam int unsigned BITS_PER_SYMBOL = 6;
    localparam int unsigned BITS_PER_AXIS   = 3;
    localparam int unsigned LEVEL_W         = 4;

    typedef enum logic {
        S0_IDLE  = 1'b0,
        S1_SHIFT = 1'b1
    } demap_state_e;

    typedef logic [BITS_PER_SYMBOL-1:0] symbol_t;
    typedef logic [BITS_PER_AXIS-1:0]   axis_idx_t;
    typedef logic [LEVEL_W-1:0]         level_t;

    localparam level_t LVL_M7 = 4'b1001;
    localparam level_t LVL_M5 = 4'b1011;
    localparam level_t LVL_M3 = 4'b1101;
    localparam level_t LVL_M1 = 4'b1111;
    localparam level_t LVL_P1 = 4'b0001;
    localparam level_t LVL_P3 = 4'b0011;
    localparam level_t LVL_P5 = 4'b0101;
    localparam level_t LVL_P7 = 4'b0111;

    // Index of the highest bit of a symbol; also the reload value of the bit counter.
    localparam logic [2:0] LAST_BIT = 3'(BITS_PER_SYMBOL - 1);

endpackage

// File: rtl/symbol_demapping_slicer.sv
// Per-axis slicer: two's-complement level to the nearest odd-level index,
// floor((v+8)/2); even inputs round up and -8 clamps to index 0.
module qam_level_slicer
    import qam64_pkg::*;
(
    input  logic [LEVEL_W-1:0]       level,
    output logic [BITS_PER_AXIS-1:0] idx
);

    always_comb begin
        idx = {~level[3], level[2], level[1]};
    end

endmodule

// File: rtl/symbol_demapping.sv
// 64-QAM demapper: pops I/Q pairs from a FWFT FIFO, slices each axis and
// shifts the 6-bit symbol out MSB-first, streaming back-to-back symbols.
module symbol_demapping
    import qam64_pkg::*;
(
    input  logic               data_clk,
    input  logic               rst_n,
    input  logic               enable_fsm,
    input  logic [LEVEL_W-1:0] i_data,
    input  logic [LEVEL_W-1:0] q_data,
    input  logic               i_q_data_fifo_empty,
    output logic               i_q_data_rd_en,
    output logic               data_out,
    output logic               data_valid,
    output logic               symbol_done
);

    demap_state_e state_q, state_d;
    symbol_t      sreg_q, sreg_d;
    logic [2:0]   bit_count_q, bit_count_d;

    axis_idx_t i_idx;
    axis_idx_t q_idx;
    logic      load;

    qam_level_slicer u_slicer_i (
        .level (i_data),
        .idx   (i_idx)
    );

    qam_level_slicer u_slicer_q (
        .level (q_data),
        .idx   (q_idx)
    );

    // A new symbol may be taken when idle or on the last bit of the current one.
    always_comb begin
        load = enable_fsm & ~i_q_data_fifo_empty &
               ((state_q == S0_IDLE) | ((state_q == S1_SHIFT) & (bit_count_q == 3'd0)));
        i_q_data_rd_en = load & rst_n;
    end

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        bit_count_d = bit_count_q;
        unique case (state_q)
            S0_IDLE: begin
                if (load) begin
                    sreg_d      = {i_idx, q_idx};
                    bit_count_d = LAST_BIT;
                    state_d     = S1_SHIFT;
                end
            end
            S1_SHIFT: begin
                if (bit_count_q != 3'd0) begin
                    sreg_d      = {sreg_q[BITS_PER_SYMBOL-2:0], 1'b0};
                    bit_count_d = bit_count_q - 3'd1;
                end else if (load) begin
                    sreg_d      = {i_idx, q_idx};
                    bit_count_d = LAST_BIT;
                end else begin
                    sreg_d  = '0;
                    state_d = S0_IDLE;
                end
            end
            default: begin
                state_d = S0_IDLE;
            end
        endcase
    end

    always_ff @(posedge data_clk) begin
        if (!rst_n) begin
            state_q     <= S0_IDLE;
            sreg_q      <= '0;
            bit_count_q <= LAST_BIT;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            bit_count_q <= bit_count_d;
        end
    end

    always_comb begin
        data_out    = sreg_q[BITS_PER_SYMBOL-1];
        data_valid  = (state_q == S1_SHIFT);
        symbol_done = (state_q == S1_SHIFT) & (bit_count_q == 3'd0);
    end

endmodule

// File: tb/tb_symbol_demapping.sv
// Directed bench for symbol_demapping with a behavioural FWFT FIFO and a
// reference 64-QAM mapper used for the loopback stream.
module tb_symbol_demapping;

    logic       data_clk;
    logic       rst_n;
    logic       enable_fsm;
    logic [3:0] i_data;
    logic [3:0] q_data;
    logic       i_q_data_fifo_empty;
    logic       i_q_data_rd_en;
    logic       data_out;
    logic       data_valid;
    logic       symbol_done;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0] fifo[$];

    logic s_rd, s_data, s_valid, s_done;

    symbol_demapping u_dut (
        .data_clk            (data_clk),
        .rst_n               (rst_n),
        .enable_fsm          (enable_fsm),
        .i_data              (i_data),
        .q_data              (q_data),
        .i_q_data_fifo_empty (i_q_data_fifo_empty),
        .i_q_data_rd_en      (i_q_data_rd_en),
        .data_out            (data_out),
        .data_valid          (data_valid),
        .symbol_done         (symbol_done)
    );

    initial data_clk = 1'b0;
    always #5 data_clk = ~data_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference transmit mapper: 3-bit index b -> level 2b-7.
    function automatic logic [3:0] map_axis(input logic [2:0] b);
        logic [3:0] v;
        v = {1'b0, b};
        return (v << 1) - 4'd7;
    endfunction

    // One clock cycle: drive FIFO head, sample outputs away from the edge, pop on rd_en.
    task automatic cycle();
        i_q_data_fifo_empty = (fifo.size() == 0);
        {i_data, q_data}    = (fifo.size() != 0) ? fifo[0] : 8'h00;
        #1;
        s_rd    = i_q_data_rd_en;
        s_data  = data_out;
        s_valid = data_valid;
        s_done  = symbol_done;
        @(posedge data_clk);
        if (s_rd && fifo.size() != 0) void'(fifo.pop_front());
        @(negedge data_clk);
    endtask

    task automatic capture(input int unsigned n, output logic [31:0] v_rd,
                           output logic [31:0] v_data, output logic [31:0] v_valid,
                           output logic [31:0] v_done);
        v_rd = '0; v_data = '0; v_valid = '0; v_done = '0;
        for (int unsigned k = 0; k < n; k++) begin
            cycle();
            v_rd[k]    = s_rd;
            v_data[k]  = s_data;
            v_valid[k] = s_valid;
            v_done[k]  = s_done;
        end
    endtask

    logic [31:0] rd_v, dat_v, val_v, don_v;
    logic [2:0]  tx_bits[$];
    logic        exp_bits[$];
    logic        rx_bits[$];
    int unsigned bad;

    initial begin
        rst_n      = 1'b0;
        enable_fsm = 1'b1;
        i_data     = '0;
        q_data     = '0;
        i_q_data_fifo_empty = 1'b1;

        // Reset held with a non-empty FIFO: no pop, outputs zero after the first edge.
        fifo.push_back({4'b1001, 4'b0111});
        capture(3, rd_v, dat_v, val_v, don_v);
        check("rst_rd_en",   rd_v,             32'h0);
        check("rst_data",    dat_v  & 32'h6,   32'h0);
        check("rst_valid",   val_v  & 32'h6,   32'h0);
        check("rst_done",    don_v  & 32'h6,   32'h0);
        check("rst_fifo",    fifo.size(),      32'd1);

        // Exact levels I=-7, Q=+7 -> 000111.
        rst_n = 1'b1;
        capture(8, rd_v, dat_v, val_v, don_v);
        check("exact_rd_en", rd_v,  32'h01);
        check("exact_data",  dat_v, 32'h70);
        check("exact_valid", val_v, 32'h7E);
        check("exact_done",  don_v, 32'h40);

        // Noisy slicing and back-to-back: 100101, 000011, 110001.
        fifo.push_back({4'b0000, 4'b0010});
        fifo.push_back({4'b1000, 4'b1110});
        fifo.push_back({4'b0101, 4'b1011});
        capture(20, rd_v, dat_v, val_v, don_v);
        check("b2b_rd_en",   rd_v,  32'h1041);
        check("b2b_data",    dat_v, 32'h47852);
        check("b2b_valid",   val_v, 32'h7FFFE);
        check("b2b_done",    don_v, 32'h41040);

        // Stall: 101011, FIFO empty, then 010100 after a gap.
        fifo.push_back({4'b0011, 4'b1111});
        capture(10, rd_v, dat_v, val_v, don_v);
        check("stall1_rd_en", rd_v,  32'h001);
        check("stall1_data",  dat_v, 32'h06A);
        check("stall1_valid", val_v, 32'h07E);
        fifo.push_back({4'b1101, 4'b0001});
        capture(8, rd_v, dat_v, val_v, don_v);
        check("stall2_rd_en", rd_v,  32'h01);
        check("stall2_data",  dat_v, 32'h14);
        check("stall2_valid", val_v, 32'h7E);
        check("stall2_done",  don_v, 32'h40);

        // enable_fsm drops mid-symbol: 111000 completes, queued symbol stays.
        fifo.push_back({4'b0111, 4'b1001});
        fifo.push_back({4'b0111, 4'b1001});
        capture(3, rd_v, dat_v, val_v, don_v);
        check("en1_rd_en", rd_v,  32'h1);
        check("en1_data",  dat_v, 32'h6);
        enable_fsm = 1'b0;
        capture(8, rd_v, dat_v, val_v, don_v);
        check("en2_rd_en", rd_v,  32'h0);
        check("en2_data",  dat_v, 32'h1);
        check("en2_valid", val_v, 32'hF);
        check("en2_done",  don_v, 32'h8);
        check("en2_fifo",  fifo.size(), 32'd1);
        fifo.delete();
        enable_fsm = 1'b1;

        // Reset during bit 3: partial 111000 dropped, next symbol 000111 intact.
        fifo.push_back({4'b0111, 4'b1001});
        fifo.push_back({4'b1001, 4'b0111});
        capture(3, rd_v, dat_v, val_v, don_v);
        check("rst3_rd_en", rd_v, 32'h1);
        rst_n = 1'b0;
        capture(1, rd_v, dat_v, val_v, don_v);
        check("rst3_hold_rd", rd_v, 32'h0);
        rst_n = 1'b1;
        capture(8, rd_v, dat_v, val_v, don_v);
        check("rst3_after_out", {dat_v[0], val_v[0], don_v[0]}, 32'h0);
        check("rst3_rd_en", rd_v,  32'h01);
        check("rst3_data",  dat_v, 32'h70);
        check("rst3_valid", val_v, 32'h7E);
        check("rst3_done",  don_v, 32'h40);

        // Loopback: 600 random bits through the reference mapper and FIFO.
        for (int unsigned s = 0; s < 100; s++) begin
            logic [5:0] w;
            w = 6'($urandom_range(0, 63));
            for (int b = 5; b >= 0; b--) exp_bits.push_back(w[b]);
            fifo.push_back({map_axis(w[5:3]), map_axis(w[2:0])});
        end
        for (int unsigned c = 0; c < 700 && rx_bits.size() < 600; c++) begin
            cycle();
            if (s_valid) rx_bits.push_back(s_data);
        end
        check("loop_len", rx_bits.size(), 32'd600);
        bad = 0;
        for (int unsigned k = 0; k < 600; k++) begin
            if (k >= rx_bits.size() || rx_bits[k] !== exp_bits[k]) bad++;
        end
        check("loop_bit_errors", bad, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
